// File: rtl/select_hand_positioner.sv
// Menu selection hand: tracks the selected item from key edges, blinks on confirm, emits hand box/offsets per pixel.
// Optional HAND_WRAP_EN makes up/down navigation wrap around instead of saturating.
module select_hand_positioner #(
  parameter int NUM_ITEMS    = 3,
  parameter int HAND_WIDTH   = 32,
  parameter int HAND_HEIGHT  = 16,
  parameter int ITEM_X       = 200,
  parameter int ITEM_Y0      = 240,
  parameter int ITEM_PITCH_Y = 48,
  parameter int BLINK_FRAMES = 15,
  parameter int BLINK_COUNT  = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        menuActive,
  input  logic        keyUp,
  input  logic        keyDown,
  input  logic        keySelect,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic [1:0]  selectedItem,
  output logic        selectValid
);

  typedef enum logic [1:0] {IDLE, BROWSE, CONFIRM, DONE} state_t;

  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int TW = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [FW-1:0] FRAME_LAST  = FW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TOGGLE_LAST = TW'(2 * BLINK_COUNT - 1);
  localparam logic [1:0]    ITEM_LAST   = 2'(NUM_ITEMS - 1);

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic            up_q, down_q, select_q;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]   toggle_cnt_q, toggle_cnt_d;
  logic            phase_q, phase_d;
  logic            inside_q, inside_d;
  logic [10:0]     off_x_q, off_x_d;
  logic [10:0]     off_y_q, off_y_d;
  logic            select_valid_q, select_valid_d;

  logic            up_edge, down_edge, select_edge;
  logic            blink_tick, last_toggle;
  logic [1:0]      sel_prev, sel_next;
  logic            visible;
  logic [10:0]     top_x, top_y;

  assign up_edge     = keyUp & ~up_q;
  assign down_edge   = keyDown & ~down_q;
  assign select_edge = keySelect & ~select_q;
  assign blink_tick  = startOfFrame && (frame_cnt_q == FRAME_LAST);
  assign last_toggle = blink_tick && (toggle_cnt_q == TOGGLE_LAST);

`ifdef HAND_WRAP_EN
  assign sel_prev = (sel_q == 2'd0) ? ITEM_LAST : sel_q - 2'd1;
  assign sel_next = (sel_q == ITEM_LAST) ? 2'd0 : sel_q + 2'd1;
`else
  assign sel_prev = (sel_q == 2'd0) ? 2'd0 : sel_q - 2'd1;
  assign sel_next = (sel_q == ITEM_LAST) ? ITEM_LAST : sel_q + 2'd1;
`endif

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= IDLE;
      sel_q          <= 2'd0;
      up_q           <= 1'b0;
      down_q         <= 1'b0;
      select_q       <= 1'b0;
      frame_cnt_q    <= '0;
      toggle_cnt_q   <= '0;
      phase_q        <= 1'b0;
      inside_q       <= 1'b0;
      off_x_q        <= 11'd0;
      off_y_q        <= 11'd0;
      select_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      up_q           <= keyUp;
      down_q         <= keyDown;
      select_q       <= keySelect;
      frame_cnt_q    <= frame_cnt_d;
      toggle_cnt_q   <= toggle_cnt_d;
      phase_q        <= phase_d;
      inside_q       <= inside_d;
      off_x_q        <= off_x_d;
      off_y_q        <= off_y_d;
      select_valid_q <= select_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (menuActive) state_d = BROWSE;
      BROWSE:  if (!menuActive) state_d = IDLE;
               else if (select_edge) state_d = CONFIRM;
      CONFIRM: if (!menuActive) state_d = IDLE;
               else if (last_toggle) state_d = DONE;
      DONE:    if (!menuActive) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Selection and blink counters; counters only run while confirming.
  always_comb begin
    sel_d        = sel_q;
    frame_cnt_d  = '0;
    toggle_cnt_d = '0;
    phase_d      = 1'b0;
    case (state_q)
      IDLE: if (menuActive) sel_d = 2'd0;
      BROWSE: begin
        if (menuActive && !select_edge) begin
          if (up_edge && !down_edge)      sel_d = sel_prev;
          else if (down_edge && !up_edge) sel_d = sel_next;
        end
      end
      CONFIRM: begin
        if (menuActive) begin
          frame_cnt_d  = frame_cnt_q;
          toggle_cnt_d = toggle_cnt_q;
          phase_d      = phase_q;
          if (blink_tick) begin
            frame_cnt_d  = '0;
            toggle_cnt_d = toggle_cnt_q + 1'b1;
            phase_d      = ~phase_q;
          end else if (startOfFrame) begin
            frame_cnt_d  = frame_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    visible        = (state_q == BROWSE) || (state_q == DONE) ||
                     ((state_q == CONFIRM) && !phase_q);
    select_valid_d = (state_q == CONFIRM) && (state_d == DONE);
    top_x          = 11'(ITEM_X);
    top_y          = 11'(ITEM_Y0 + int'(sel_q) * ITEM_PITCH_Y);
    inside_d       = visible &&
                     ({1'b0, pixelX} >= {1'b0, top_x}) &&
                     ({1'b0, pixelX} <  {1'b0, top_x} + 12'(HAND_WIDTH)) &&
                     ({1'b0, pixelY} >= {1'b0, top_y}) &&
                     ({1'b0, pixelY} <  {1'b0, top_y} + 12'(HAND_HEIGHT));
    off_x_d        = inside_d ? pixelX - top_x : 11'd0;
    off_y_d        = inside_d ? pixelY - top_y : 11'd0;
  end

  assign InsideRectangle = inside_q;
  assign offsetX         = off_x_q;
  assign offsetY         = off_y_q;
  assign selectedItem    = sel_q;
  assign selectValid     = select_valid_q;

endmodule

// File: tb/tb_select_hand_positioner.sv
// Directed bench for select_hand_positioner (default parameters, either HAND_WRAP_EN setting).
module tb_select_hand_positioner;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = 11'd0;
  logic [10:0] pixelY = 11'd0;
  logic        startOfFrame = 1'b0;
  logic        menuActive = 1'b0;
  logic        keyUp = 1'b0;
  logic        keyDown = 1'b0;
  logic        keySelect = 1'b0;
  logic        InsideRectangle;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [1:0]  selectedItem;
  logic        selectValid;

  int tests_run = 0;
  int tests_failed = 0;
  int sv_count = 0;

  select_hand_positioner dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .menuActive(menuActive),
    .keyUp(keyUp), .keyDown(keyDown), .keySelect(keySelect),
    .InsideRectangle(InsideRectangle), .offsetX(offsetX), .offsetY(offsetY),
    .selectedItem(selectedItem), .selectValid(selectValid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (selectValid === 1'b1) sv_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic up, input logic dn, input logic sl);
    keyUp = up; keyDown = dn; keySelect = sl;
    tick(2);
    keyUp = 1'b0; keyDown = 1'b0; keySelect = 1'b0;
    tick(2);
  endtask

  task automatic frame_pulse();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    tick(2);
  endtask

  task automatic set_pixel(input int x, input int y);
    pixelX = 11'(x); pixelY = 11'(y);
    tick(1);
  endtask

  task automatic renormalize();
    menuActive = 1'b0; tick(2);
    menuActive = 1'b1; tick(2);
  endtask

  task automatic test_reset();
    resetN = 1'b0; menuActive = 1'b0;
    pixelX = 11'd210; pixelY = 11'd245;
    tick(3);
    tests_run++; if (InsideRectangle !== 1'b0) begin tests_failed++; $display("FAIL reset_inside got %0b want 0", InsideRectangle); end
    tests_run++; if (offsetX !== 11'd0 || offsetY !== 11'd0) begin tests_failed++; $display("FAIL reset_offsets got %0d,%0d want 0,0", offsetX, offsetY); end
    tests_run++; if (selectedItem !== 2'd0) begin tests_failed++; $display("FAIL reset_sel got %0d want 0", selectedItem); end
    tests_run++; if (selectValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", selectValid); end
    resetN = 1'b1;
    tick(2);
    tests_run++; if (InsideRectangle !== 1'b0) begin tests_failed++; $display("FAIL idle_hidden got %0b want 0", InsideRectangle); end
  endtask

  task automatic test_browse_pixels();
    menuActive = 1'b1;
    tick(2);
    tests_run++; if (selectedItem !== 2'd0) begin tests_failed++; $display("FAIL browse_sel got %0d want 0", selectedItem); end
    set_pixel(210, 245);
    tests_run++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd10, 11'd5}) begin tests_failed++; $display("FAIL pix_210_245 got %0b/%0d/%0d want 1/10/5", InsideRectangle, offsetX, offsetY); end
    set_pixel(232, 245);
    tests_run++; if ({InsideRectangle, offsetX, offsetY} !== {1'b0, 11'd0, 11'd0}) begin tests_failed++; $display("FAIL pix_232_245 got %0b/%0d/%0d want 0/0/0", InsideRectangle, offsetX, offsetY); end
    set_pixel(231, 255);
    tests_run++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd31, 11'd15}) begin tests_failed++; $display("FAIL pix_231_255 got %0b/%0d/%0d want 1/31/15", InsideRectangle, offsetX, offsetY); end
    set_pixel(210, 256);
    tests_run++; if ({InsideRectangle, offsetX, offsetY} !== {1'b0, 11'd0, 11'd0}) begin tests_failed++; $display("FAIL pix_210_256 got %0b/%0d/%0d want 0/0/0", InsideRectangle, offsetX, offsetY); end
    set_pixel(199, 245);
    tests_run++; if (InsideRectangle !== 1'b0) begin tests_failed++; $display("FAIL pix_199_245 got %0b want 0", InsideRectangle); end
  endtask

  task automatic test_navigation();
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    tests_run++; if (selectedItem !== 2'd2) begin tests_failed++; $display("FAIL down_twice got %0d want 2", selectedItem); end
    set_pixel(200, 336);
    tests_run++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd0, 11'd0}) begin tests_failed++; $display("FAIL pix_200_336 got %0b/%0d/%0d want 1/0/0", InsideRectangle, offsetX, offsetY); end
    set_pixel(199, 336);
    tests_run++; if (InsideRectangle !== 1'b0) begin tests_failed++; $display("FAIL pix_199_336 got %0b want 0", InsideRectangle); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    tests_run++; if (selectedItem !== 2'd0) begin tests_failed++; $display("FAIL up_twice got %0d want 0", selectedItem); end
    keyDown = 1'b1;
    tick(100);
    tests_run++; if (selectedItem !== 2'd1) begin tests_failed++; $display("FAIL hold_down got %0d want 1", selectedItem); end
    keyDown = 1'b0;
    tick(2);
    tests_run++; if (selectedItem !== 2'd1) begin tests_failed++; $display("FAIL hold_release got %0d want 1", selectedItem); end
  endtask

  task automatic test_boundaries();
    logic [1:0] exp_up, exp_dn;
`ifdef HAND_WRAP_EN
    exp_up = 2'd2; exp_dn = 2'd0;
`else
    exp_up = 2'd0; exp_dn = 2'd2;
`endif
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    tests_run++; if (selectedItem !== exp_up) begin tests_failed++; $display("FAIL up_at_0 got %0d want %0d", selectedItem, exp_up); end
    renormalize();
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    tests_run++; if (selectedItem !== exp_dn) begin tests_failed++; $display("FAIL down_at_last got %0d want %0d", selectedItem, exp_dn); end
    renormalize();
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    tests_run++; if (selectedItem !== 2'd1) begin tests_failed++; $display("FAIL up_down_same got %0d want 1", selectedItem); end
  endtask

  task automatic test_confirm();
    int  sv0;
    logic exp_vis;
    sv0 = sv_count;
    press(1'b0, 1'b0, 1'b1);
    set_pixel(205, 290);
    tests_run++; if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd5, 11'd2}) begin tests_failed++; $display("FAIL confirm_start got %0b/%0d/%0d want 1/5/2", InsideRectangle, offsetX, offsetY); end
    for (int k = 1; k <= 90; k++) begin
      frame_pulse();
      if (k == 40) press(1'b1, 1'b0, 1'b0);
      if (k == 50) begin
        press(1'b0, 1'b1, 1'b0);
        tests_run++; if (selectedItem !== 2'd1) begin tests_failed++; $display("FAIL confirm_keys got %0d want 1", selectedItem); end
      end
      exp_vis = ((k / 15) % 2) == 0;
      tests_run++; if (InsideRectangle !== exp_vis) begin tests_failed++; $display("FAIL confirm_vis frame %0d got %0b want %0b", k, InsideRectangle, exp_vis); end
      if (k == 89) begin
        tests_run++; if (sv_count !== sv0) begin tests_failed++; $display("FAIL early_valid got %0d pulses want 0", sv_count - sv0); end
      end
    end
    tests_run++; if (sv_count !== sv0 + 1) begin tests_failed++; $display("FAIL done_valid got %0d pulses want 1", sv_count - sv0); end
    tests_run++; if (selectedItem !== 2'd1) begin tests_failed++; $display("FAIL done_sel got %0d want 1", selectedItem); end
    tick(10);
    tests_run++; if (sv_count !== sv0 + 1) begin tests_failed++; $display("FAIL done_single got %0d pulses want 1", sv_count - sv0); end
    tests_run++; if (InsideRectangle !== 1'b1) begin tests_failed++; $display("FAIL done_visible got %0b want 1", InsideRectangle); end
  endtask

  task automatic test_reset_in_done();
    resetN = 1'b0;
    tick(1);
    tests_run++; if ({InsideRectangle, offsetX, offsetY} !== {1'b0, 11'd0, 11'd0}) begin tests_failed++; $display("FAIL rst_done_box got %0b/%0d/%0d want 0/0/0", InsideRectangle, offsetX, offsetY); end
    tests_run++; if ({selectedItem, selectValid} !== 3'b000) begin tests_failed++; $display("FAIL rst_done_sel got %0d/%0b want 0/0", selectedItem, selectValid); end
    resetN = 1'b1;
    tick(1);
    tests_run++; if (InsideRectangle !== 1'b0) begin tests_failed++; $display("FAIL rst_idle got %0b want 0", InsideRectangle); end
    set_pixel(205, 245);
    tests_run++; if ({InsideRectangle, offsetX, offsetY, selectedItem} !== {1'b1, 11'd5, 11'd5, 2'd0}) begin tests_failed++; $display("FAIL rst_rebrowse got %0b/%0d/%0d/%0d want 1/5/5/0", InsideRectangle, offsetX, offsetY, selectedItem); end
  endtask

  task automatic test_abort();
    int sv0;
    renormalize();
    press(1'b0, 1'b1, 1'b0);
    sv0 = sv_count;
    press(1'b0, 1'b0, 1'b1);
    repeat (20) frame_pulse();
    menuActive = 1'b0;
    tick(2);
    set_pixel(205, 290);
    tests_run++; if ({InsideRectangle, offsetX, offsetY} !== {1'b0, 11'd0, 11'd0}) begin tests_failed++; $display("FAIL abort_item1 got %0b/%0d/%0d want 0/0/0", InsideRectangle, offsetX, offsetY); end
    set_pixel(205, 245);
    tests_run++; if (InsideRectangle !== 1'b0) begin tests_failed++; $display("FAIL abort_item0 got %0b want 0", InsideRectangle); end
    repeat (80) frame_pulse();
    tests_run++; if (sv_count !== sv0) begin tests_failed++; $display("FAIL abort_valid got %0d pulses want 0", sv_count - sv0); end
  endtask

  initial begin
    test_reset();
    test_browse_pixels();
    test_navigation();
    test_boundaries();
    test_confirm();
    test_reset_in_done();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
